// File: rtl/pulse_seq_bank.sv
// Bank of N_CH independent delay-then-periodic laser pulse sequencers, programmed through a register-write port.
// Latency: a register write takes effect at the edge that samples it; outputs are registered decodes of next state.
// Backpressure: none, every write strobe is accepted in its cycle; writes to unmapped addresses are dropped.
module pulse_seq_bank #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_wr,
    input  logic [7:0]      reg_addr,
    input  logic [31:0]     reg_data,
    output logic [N_CH-1:0] laser_en,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_e;

    localparam logic [3:0] GLOBAL_CH = 4'hF;
    localparam logic [3:0] F_INIT    = 4'd0;
    localparam logic [3:0] F_LOW     = 4'd1;
    localparam logic [3:0] F_HIGH    = 4'd2;
    localparam logic [3:0] F_BURST   = 4'd3;
    localparam logic [3:0] F_START   = 4'd0;
    localparam logic [3:0] F_STOP    = 4'd1;

    // Shadow configuration registers
    logic [CNT_W-1:0]   init_q  [N_CH];
    logic [CNT_W-1:0]   init_d  [N_CH];
    logic [CNT_W-1:0]   low_q   [N_CH];
    logic [CNT_W-1:0]   low_d   [N_CH];
    logic [CNT_W-1:0]   high_q  [N_CH];
    logic [CNT_W-1:0]   high_d  [N_CH];
    logic [BURST_W-1:0] burst_q [N_CH];
    logic [BURST_W-1:0] burst_d [N_CH];

    // Sequencer state
    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [CNT_W-1:0]   cnt_q   [N_CH];
    logic [CNT_W-1:0]   cnt_d   [N_CH];
    logic [BURST_W-1:0] pcnt_q  [N_CH];
    logic [BURST_W-1:0] pcnt_d  [N_CH];

    logic [N_CH-1:0]    laser_en_q, laser_en_d;
    logic [N_CH-1:0]    busy_q, busy_d;
    logic [N_CH-1:0]    done_q, done_d;

    logic               glob_wr;
    logic [N_CH-1:0]    start_vec;
    logic [N_CH-1:0]    stop_vec;

    // A zero count still occupies one cycle so no phase is ever skipped.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    always_comb begin
        glob_wr   = reg_wr && (reg_addr[7:4] == GLOBAL_CH);
        start_vec = '0;
        stop_vec  = '0;
        if (glob_wr && (reg_addr[3:0] == F_START)) begin
            start_vec = reg_data[N_CH-1:0];
        end
        if (glob_wr && (reg_addr[3:0] == F_STOP)) begin
            stop_vec = reg_data[N_CH-1:0];
        end
    end

    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            init_d[ch]  = init_q[ch];
            low_d[ch]   = low_q[ch];
            high_d[ch]  = high_q[ch];
            burst_d[ch] = burst_q[ch];
            if (reg_wr && (reg_addr[7:4] == 4'(ch))) begin
                case (reg_addr[3:0])
                    F_INIT:  init_d[ch]  = reg_data[CNT_W-1:0];
                    F_LOW:   low_d[ch]   = reg_data[CNT_W-1:0];
                    F_HIGH:  high_d[ch]  = reg_data[CNT_W-1:0];
                    F_BURST: burst_d[ch] = reg_data[BURST_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Counters reload from the shadow registers only on phase entry, so a
    // config write never disturbs the phase already in progress.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            pcnt_d[ch]  = pcnt_q[ch];
            done_d[ch]  = 1'b0;

            case (state_q[ch])
                S_INIT: begin
                    if (cnt_q[ch] == CNT_W'(1)) begin
                        state_d[ch] = S_HIGH;
                        cnt_d[ch]   = at_least_one(high_q[ch]);
                    end else begin
                        cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q[ch] == CNT_W'(1)) begin
                        pcnt_d[ch] = pcnt_q[ch] + BURST_W'(1);
                        if ((burst_q[ch] != '0) && (pcnt_q[ch] + BURST_W'(1) == burst_q[ch])) begin
                            state_d[ch] = S_IDLE;
                            done_d[ch]  = 1'b1;
                        end else begin
                            state_d[ch] = S_LOW;
                            cnt_d[ch]   = at_least_one(low_q[ch]);
                        end
                    end else begin
                        cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (cnt_q[ch] == CNT_W'(1)) begin
                        state_d[ch] = S_HIGH;
                        cnt_d[ch]   = at_least_one(high_q[ch]);
                    end else begin
                        cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (start_vec[ch]) begin
                state_d[ch] = S_INIT;
                cnt_d[ch]   = at_least_one(init_q[ch]);
                pcnt_d[ch]  = '0;
                done_d[ch]  = 1'b0;
            end

            // Stop beats natural completion and is harmless on an idle channel.
            if (stop_vec[ch]) begin
                state_d[ch] = S_IDLE;
                done_d[ch]  = 1'b0;
            end

            laser_en_d[ch] = (state_d[ch] == S_HIGH);
            busy_d[ch]     = (state_d[ch] != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                init_q[ch]  <= '0;
                low_q[ch]   <= '0;
                high_q[ch]  <= '0;
                burst_q[ch] <= '0;
                state_q[ch] <= S_IDLE;
                cnt_q[ch]   <= '0;
                pcnt_q[ch]  <= '0;
            end
            laser_en_q <= '0;
            busy_q     <= '0;
            done_q     <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                init_q[ch]  <= init_d[ch];
                low_q[ch]   <= low_d[ch];
                high_q[ch]  <= high_d[ch];
                burst_q[ch] <= burst_d[ch];
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                pcnt_q[ch]  <= pcnt_d[ch];
            end
            laser_en_q <= laser_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign laser_en = laser_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pulse_seq_bank.sv
// Directed bench for pulse_seq_bank: per-cycle traces after a start edge compared to hand-derived bit patterns.
module tb_pulse_seq_bank;

    localparam int N_CH = 4;

    logic            clk;
    logic            reset;
    logic            reg_wr;
    logic [7:0]      reg_addr;
    logic [31:0]     reg_data;
    logic [N_CH-1:0] laser_en;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] done;

    int n_checks;
    int n_errors;
    int idx;

    // Index k holds the outputs seen after edge E+k, E being the start edge.
    logic [N_CH-1:0] le_tr   [0:63];
    logic [N_CH-1:0] busy_tr [0:63];
    logic [N_CH-1:0] done_tr [0:63];

    pulse_seq_bank #(.N_CH(N_CH), .CNT_W(32), .BURST_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .laser_en (laser_en),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (idx < 64) begin
            le_tr[idx]   = laser_en;
            busy_tr[idx] = busy;
            done_tr[idx] = done;
        end
        idx++;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_addr = a;
        reg_data = d;
        reg_wr   = 1'b1;
        tick();
        reg_wr   = 1'b0;
        reg_addr = 8'h00;
        reg_data = 32'h0;
    endtask

    // kind: 0 laser_en, 1 busy, 2 done
    function automatic logic [63:0] trace_of(input int kind, input int ch, input int n);
        logic [63:0] t;
        t = '0;
        for (int k = 0; k < n; k++) begin
            case (kind)
                0:       t[k] = le_tr[k][ch];
                1:       t[k] = busy_tr[k][ch];
                default: t[k] = done_tr[k][ch];
            endcase
        end
        return t;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        idx      = 0;
        reset    = 1'b1;
        reg_wr   = 1'b0;
        reg_addr = 8'h00;
        reg_data = 32'h0;

        #2;
        chk("rst_laser", 64'(laser_en), 64'h0);
        chk("rst_busy",  64'(busy),     64'h0);
        chk("rst_done",  64'(done),     64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Continuous train, period 5
        wr(8'h00, 32'd4);
        wr(8'h01, 32'd3);
        wr(8'h02, 32'd2);
        wr(8'h03, 32'd0);
        idx = 0;
        wr(8'hF0, 32'h1);
        repeat (19) tick();
        chk("cont_laser", trace_of(0, 0, 20), 64'h8C630);
        chk("cont_busy",  trace_of(1, 0, 20), 64'hFFFFF);
        chk("cont_done",  trace_of(2, 0, 20), 64'h0);
        wr(8'hF1, 32'h1);
        chk("stop_laser", 64'(laser_en[0]), 64'h0);
        chk("stop_busy",  64'(busy[0]),     64'h0);

        // Finite burst of 3
        wr(8'h10, 32'd1);
        wr(8'h11, 32'd2);
        wr(8'h12, 32'd1);
        wr(8'h13, 32'd3);
        idx = 0;
        wr(8'hF0, 32'h2);
        repeat (11) tick();
        chk("burst_laser", trace_of(0, 1, 12), 64'h92);
        chk("burst_busy",  trace_of(1, 1, 12), 64'hFF);
        chk("burst_done",  trace_of(2, 1, 12), 64'h100);

        // Two channels from one mask write
        wr(8'h00, 32'd3);
        wr(8'h01, 32'd1);
        wr(8'h02, 32'd2);
        wr(8'h03, 32'd0);
        wr(8'h20, 32'd3);
        wr(8'h21, 32'd4);
        wr(8'h22, 32'd1);
        wr(8'h23, 32'd0);
        idx = 0;
        wr(8'hF0, 32'h5);
        repeat (11) tick();
        chk("pair_ch0_laser", trace_of(0, 0, 12), 64'h6D8);
        chk("pair_ch0_busy",  trace_of(1, 0, 12), 64'hFFF);
        chk("pair_ch2_laser", trace_of(0, 2, 12), 64'h108);
        chk("pair_ch1_idle",  trace_of(0, 1, 12) | trace_of(1, 1, 12), 64'h0);
        chk("pair_ch3_idle",  trace_of(0, 3, 12) | trace_of(1, 3, 12), 64'h0);
        wr(8'hF1, 32'h5);
        chk("pair_stop_busy", 64'(busy), 64'h0);

        // Zero counts toggle every cycle; burst data truncated to 16 bits -> 3
        wr(8'h00, 32'd0);
        wr(8'h01, 32'd0);
        wr(8'h02, 32'd0);
        wr(8'h03, 32'h0001_0003);
        idx = 0;
        wr(8'hF0, 32'h1);
        repeat (9) tick();
        chk("zero_laser", trace_of(0, 0, 10), 64'h2A);
        chk("zero_busy",  trace_of(1, 0, 10), 64'h3F);
        chk("zero_done",  trace_of(2, 0, 10), 64'h40);

        // High rewritten mid-pulse, then stop mid-pulse
        wr(8'h00, 32'd2);
        wr(8'h01, 32'd2);
        wr(8'h02, 32'd3);
        wr(8'h03, 32'd0);
        idx = 0;
        wr(8'hF0, 32'h1);
        tick();
        tick();
        wr(8'h02, 32'd5);
        repeat (10) tick();
        chk("midwr_laser", trace_of(0, 0, 14), 64'hF9C);
        tick();
        chk("prestop_laser", 64'(laser_en[0]), 64'h1);
        wr(8'hF1, 32'h1);
        chk("midstop_laser", 64'(laser_en[0]), 64'h0);
        chk("midstop_busy",  64'(busy[0]),     64'h0);
        repeat (4) tick();
        chk("midstop_done", trace_of(2, 0, 20), 64'h0);

        // Asynchronous reset mid-burst, then restart with cleared config
        wr(8'h10, 32'd1);
        wr(8'h11, 32'd1);
        wr(8'h12, 32'd4);
        wr(8'h13, 32'd5);
        idx = 0;
        wr(8'hF0, 32'h2);
        tick();
        tick();
        chk("prerst_laser", 64'(laser_en[1]), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_laser", 64'(laser_en), 64'h0);
        chk("arst_busy",  64'(busy),     64'h0);
        chk("arst_done",  64'(done),     64'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        idx = 0;
        wr(8'hF0, 32'h2);
        repeat (7) tick();
        chk("post_rst_laser", trace_of(0, 1, 8), 64'hAA);
        chk("post_rst_busy",  trace_of(1, 1, 8), 64'hFF);
        chk("post_rst_done",  trace_of(2, 1, 8), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
